// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_sub_pkg;

   // FSM states. The 2-bit encoding is fixed so that anything decoding state
   // outside the top module sees stable values.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The bit counter must hold the values 0..width, so it needs clog2(width+1) bits.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : serial_sub_pkg

// File: rtl/half_subtractor.sv
// One-bit half subtractor, purely combinational: diff = x - y, bout = borrow out.
// Latency: 0 cycles (combinational).
// Backpressure: none; no handshake.
// Ports: x (minuend bit), y (subtrahend bit), diff (x ^ y), bout (~x & y).
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y;
   assign bout = ~x & y;

endmodule : half_subtractor

// File: rtl/serial_half_sub.sv
// Bit-serial unsigned subtractor: diff = a_in - b_in mod 2^WIDTH, borrow = (a_in < b_in), LSB first.
// Latency: WIDTH+1 edges from the accepting edge (inclusive) to done; next accept WIDTH+2 cycles later.
// Backpressure: start is only honoured in IDLE; requests made while busy or done are dropped, not queued.
// Ports: clk, rst (sync, active-high); start, a_in, b_in (request + operands);
//        busy (RUN), done (1-cycle DONE pulse), diff/borrow (registered result, held between ops).
module serial_half_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;     // minuend, shifted right one bit per RUN cycle
   logic [WIDTH-1:0] b_sh;     // subtrahend, shifted in lockstep with a_sh
   logic [WIDTH-1:0] res_sh;   // partial result, filled from the MSB end
   logic             br;       // running borrow between bit positions
   logic [CW-1:0]    bit_cnt;  // index of the bit processed on the next RUN edge

   // Full-subtractor step from two half subtractors:
   //   stage 0: a - b        -> partial difference, borrow when a=0,b=1
   //   stage 1: partial - br -> final bit, borrow when partial=0,br=1
   // The two stage borrows are mutually exclusive, so OR-ing them gives
   // br_next = (~a & b) | (~(a ^ b) & br).
   logic hs0_d;
   logic hs0_b;
   logic hs1_b;
   logic step_d;
   logic step_br;

   half_subtractor u_hs0 (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .diff (hs0_d),
      .bout (hs0_b)
   );

   half_subtractor u_hs1 (
      .x    (hs0_d),
      .y    (br),
      .diff (step_d),
      .bout (hs1_b)
   );

   assign step_br = hs0_b | hs1_b;

   // After WIDTH shifts from the MSB end, bit 0's result has reached bit 0.
   logic [WIDTH-1:0] res_next;
   assign res_next = {step_d, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         br      <= 1'b0;
         bit_cnt <= '0;
         diff    <= '0;
         borrow  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh    <= a_in;
                  b_sh    <= b_in;
                  res_sh  <= '0;
                  br      <= 1'b0;
                  bit_cnt <= '0;
                  state   <= ST_RUN;
               end
            end

            ST_RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               res_sh  <= res_next;
               br      <= step_br;
               bit_cnt <= bit_cnt + 1'b1;
               // Publish the result on the same edge that processes the
               // last bit, so diff/borrow are valid throughout DONE.
               if (bit_cnt == LAST) begin
                  diff   <= res_next;
                  borrow <= step_br;
                  state  <= ST_DONE;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Status is a pure decode of registered state: no input-to-output path.
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule : serial_half_sub

// File: tb/tb_serial_half_sub.sv
// Self-checking bench for serial_half_sub (WIDTH=8): vector table, corner sequences, random sweep.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_half_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;

   int checks = 0;
   int errors = 0;

   // Result the DUT is expected to be holding between operations.
   logic [W-1:0] held_d;
   logic         held_b;

   serial_half_sub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Reference model: plain integer subtraction, wrapped to W bits.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
      int v;
      v = int'(a) - int'(b);
      if (v < 0) v += (1 << W);
      return W'(v);
   endfunction

   function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
      return int'(a) < int'(b);
   endfunction

   // Runs one operation from IDLE. Edge n=1 is the accepting edge; the DUT must
   // be busy after edges 1..W, show done after edge W+1 and be idle after W+2.
   // Operands are scrambled after acceptance to expose any re-sampling.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rd, output logic rb, output bit tim_ok);
      tim_ok = 1'b1;
      rd = 'x;
      rb = 1'bx;
      @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      for (int n = 1; n <= W + 2; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            a_in  = W'($urandom_range(0, (1 << W) - 1));
            b_in  = W'($urandom_range(0, (1 << W) - 1));
         end
         if (busy !== (n <= W)) tim_ok = 1'b0;
         if (done !== (n == W + 1)) tim_ok = 1'b0;
         if (n <= W && (diff !== held_d || borrow !== held_b)) tim_ok = 1'b0;
         if (n == W + 1) begin
            rd = diff;
            rb = borrow;
         end
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         br;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [W-1:0] rd;
      logic         rb;
      bit           tok;
      int           dones;
      logic [W-1:0] ra, rbv;

      vecs[0] = '{a: 8'd5,   b: 8'd3,   d: 8'd2,   br: 1'b0};
      vecs[1] = '{a: 8'd3,   b: 8'd5,   d: 8'hFE,  br: 1'b1};
      vecs[2] = '{a: 8'd0,   b: 8'd1,   d: 8'hFF,  br: 1'b1};
      vecs[3] = '{a: 8'hFF,  b: 8'hFF,  d: 8'h00,  br: 1'b0};
      vecs[4] = '{a: 8'd0,   b: 8'd0,   d: 8'h00,  br: 1'b0};
      vecs[5] = '{a: 8'd0,   b: 8'hFF,  d: 8'h01,  br: 1'b1};
      vecs[6] = '{a: 8'hFF,  b: 8'd0,   d: 8'hFF,  br: 1'b0};
      vecs[7] = '{a: 8'h80,  b: 8'h7F,  d: 8'h01,  br: 1'b0};
      vecs[8] = '{a: 8'h7F,  b: 8'h80,  d: 8'hFF,  br: 1'b1};
      vecs[9] = '{a: 8'd100, b: 8'd37,  d: 8'd63,  br: 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_borrow", borrow, 0);
      held_d = '0;
      held_b = 1'b0;

      // Reset wins over a simultaneous start.
      start = 1'b1;
      a_in  = 8'd9;
      b_in  = 8'd2;
      @(posedge clk);
      @(negedge clk);
      check("rst_priority_busy", busy, 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("idle_no_start_busy", busy, 0);

      // Directed vector table.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, rd, rb, tok);
         check($sformatf("vec%0d_diff", i), rd, vecs[i].d);
         check($sformatf("vec%0d_borrow", i), rb, vecs[i].br);
         check($sformatf("vec%0d_timing", i), tok, 1);
         held_d = vecs[i].d;
         held_b = vecs[i].br;
      end

      // start held high with operands changed mid-RUN: one done, first operands.
      @(negedge clk);
      start = 1'b1;
      a_in  = 8'h30;
      b_in  = 8'h10;
      dones = 0;
      tok   = 1'b1;
      for (int n = 1; n <= W + 2; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 2) begin
            a_in = 8'h01;
            b_in = 8'h02;
         end
         if (done === 1'b1) begin
            dones++;
            rd = diff;
            rb = borrow;
         end
         if (busy !== (n <= W)) tok = 1'b0;
      end
      check("held_start_done_count", dones, 1);
      check("held_start_diff", rd, 8'h20);
      check("held_start_borrow", rb, 0);
      check("held_start_timing", tok, 1);
      // Now idle with start still high: the next edge accepts the new operands.
      @(posedge clk);
      @(negedge clk);
      check("held_start_reaccept_busy", busy, 1);
      start = 1'b0;
      dones = 0;
      for (int n = 2; n <= W + 2; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            rd = diff;
            rb = borrow;
         end
      end
      check("second_op_done_count", dones, 1);
      check("second_op_diff", rd, 8'hFF);
      check("second_op_borrow", rb, 1);
      held_d = 8'hFF;
      held_b = 1'b1;

      // Reset on RUN cycle 4 aborts the operation.
      @(negedge clk);
      start = 1'b1;
      a_in  = 8'd200;
      b_in  = 8'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_abort_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_borrow", borrow, 0);
      dones = 0;
      repeat (W + 2) begin
         @(posedge clk);
         @(negedge clk);
         if (done !== 1'b0) dones++;
      end
      check("abort_no_done", dones, 0);
      held_d = '0;
      held_b = 1'b0;
      run_op(8'd10, 8'd4, rd, rb, tok);
      check("after_abort_diff", rd, 8'd6);
      check("after_abort_borrow", rb, 0);
      check("after_abort_timing", tok, 1);
      held_d = 8'd6;
      held_b = 1'b0;

      // Random sweep against the arithmetic reference.
      for (int k = 0; k < 1000; k++) begin
         ra  = W'($urandom_range(0, (1 << W) - 1));
         rbv = W'($urandom_range(0, (1 << W) - 1));
         run_op(ra, rbv, rd, rb, tok);
         check($sformatf("rand%0d_diff a=%0d b=%0d", k, ra, rbv), rd, ref_diff(ra, rbv));
         check($sformatf("rand%0d_borrow a=%0d b=%0d", k, ra, rbv), rb, ref_borrow(ra, rbv));
         check($sformatf("rand%0d_timing", k), tok, 1);
         held_d = ref_diff(ra, rbv);
         held_b = ref_borrow(ra, rbv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_half_sub
